// File: rtl/swan_pkg.sv
// Shared SWAN256 definitions: block geometry, vartheta rotation amounts and
// the round-engine state encoding.
package swan_pkg;

  localparam int unsigned BLOCK_SIZE  = 256;
  localparam int unsigned SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int unsigned COLUMN_SIZE = 32;

  localparam int unsigned PA = 1;
  localparam int unsigned PB = 9;
  localparam int unsigned PC = 19;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Rotate toward the LSB end; MSB-first bit numbering makes that the higher index.
  function automatic logic [COLUMN_SIZE-1:0] rotr(input logic [COLUMN_SIZE-1:0] c,
                                                  input int unsigned n);
    return (c >> n) | (c << (COLUMN_SIZE - n));
  endfunction

endpackage

// File: rtl/vartheta.sv
// SWAN256 column-rotation diffusion stage: four 32-bit columns, c0 at the MSB
// end, rotated right by PC, PB, PA and zero respectively.
module vartheta
  import swan_pkg::*;
(
  input  logic [0:SIDE_SIZE-1] x_i,
  output logic [0:SIDE_SIZE-1] y_o
);

  assign y_o = {rotr(x_i[0:31], PC),
                rotr(x_i[32:63], PB),
                rotr(x_i[64:95], PA),
                x_i[96:127]};

endmodule

// File: rtl/swan_round_iter.sv
// Iterative SWAN256 engine: one Feistel round per clock over two 128-bit halves,
// round keys fetched combinationally from the key schedule via rk_idx.
module swan_round_iter
  import swan_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:BLOCK_SIZE-1] din,
  output logic [7:0]            rk_idx,
  input  logic [0:SIDE_SIZE-1]  rk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_SIZE-1] dout
);

  localparam logic [7:0] LastRound = 8'(ROUNDS - 1);

  state_e               state_q, state_d;
  logic [0:SIDE_SIZE-1] l_q, l_d, r_q, r_d;
  logic [0:SIDE_SIZE-1] mix, f;
  logic [7:0]           cnt_q, cnt_d;

  assign mix = l_q ^ rk;

  vartheta u_vartheta (
    .x_i(mix),
    .y_o(f)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          l_d     = din[0:SIDE_SIZE-1];
          r_d     = din[SIDE_SIZE:BLOCK_SIZE-1];
          cnt_d   = 8'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        l_d   = r_q ^ f;
        r_d   = l_q;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastRound) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign rk_idx    = (state_q == StRun) ? cnt_q : 8'd0;
  assign dout      = {l_q, r_q};

endmodule

// File: tb/tb_swan_round_iter.sv
// Scoreboard bench for swan_round_iter: a one-round instance for hand-computed
// vectors and a 64-round instance checked against a reference model.
module tb_swan_round_iter;

  typedef struct {
    logic [255:0] data;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [255:0] din1 = '0, dout1;
  logic [127:0] rk1 = '0;
  logic [7:0]   rk_idx1;

  logic         in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b0;
  logic [255:0] din64 = '0, dout64;
  logic [127:0] rk64;
  logic [7:0]   rk_idx64;

  logic [127:0] rk_tab [64];
  exp_t q1[$];
  exp_t q64[$];
  logic ov1_prev = 1'b0, ov64_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk64 = rk_tab[rk_idx64[5:0]];

  swan_round_iter #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
    .rk_idx(rk_idx1), .rk(rk1), .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1)
  );

  swan_round_iter #(.ROUNDS(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64), .din(din64),
    .rk_idx(rk_idx64), .rk(rk64), .out_valid(out_valid64), .out_ready(out_ready64),
    .dout(dout64)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr(input logic [31:0] c, input int n);
    logic [63:0] d;
    d = {c, c} >> n;
    return d[31:0];
  endfunction

  function automatic logic [127:0] vth(input logic [127:0] x);
    return {rr(x[127:96], 19), rr(x[95:64], 9), rr(x[63:32], 1), x[31:0]};
  endfunction

  function automatic logic [255:0] model64(input logic [255:0] blk);
    logic [127:0] l, r, t;
    l = blk[255:128];
    r = blk[127:0];
    for (int i = 0; i < 64; i++) begin
      t = r ^ vth(l ^ rk_tab[i]);
      r = l;
      l = t;
    end
    return {l, r};
  endfunction

  // Monitors: compare each completed output and the latency from its accept edge.
  always @(negedge clk) begin
    if (rst_n && out_valid1 && !ov1_prev) begin
      if (q1.size() == 0) chk("rise1_unexpected", 1, 0);
      else chk("latency1", 256'(cyc - q1[0].acc), 256'd1);
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("out1_unexpected", 1, 0);
      else begin
        chk("dout1", dout1, q1[0].data);
        void'(q1.pop_front());
      end
    end
    ov1_prev <= out_valid1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid64 && !ov64_prev) begin
      if (q64.size() == 0) chk("rise64_unexpected", 1, 0);
      else chk("latency64", 256'(cyc - q64[0].acc), 256'd64);
    end
    if (rst_n && out_valid64 && out_ready64) begin
      if (q64.size() == 0) chk("out64_unexpected", 1, 0);
      else begin
        chk("dout64", dout64, q64[0].data);
        void'(q64.pop_front());
      end
    end
    ov64_prev <= out_valid64;
  end

  task automatic send1(input logic [255:0] d, input logic [127:0] k, input logic [255:0] e);
    int n = 0;
    in_valid1 = 1'b1;
    din1 = d;
    rk1 = k;
    while (!in_ready1 && n < 300) begin tick(); n++; end
    if (!in_ready1) chk("accept1_timeout", 0, 1);
    tick();
    in_valid1 = 1'b0;
    q1.push_back('{data: e, acc: cyc});
  endtask

  task automatic send64(input logic [255:0] d, output int acc);
    int n = 0;
    in_valid64 = 1'b1;
    din64 = d;
    while (!in_ready64 && n < 300) begin tick(); n++; end
    if (!in_ready64) chk("accept64_timeout", 0, 1);
    tick();
    acc = cyc;
    in_valid64 = 1'b0;
    q64.push_back('{data: model64(d), acc: acc});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q1.size() != 0 || q64.size() != 0) && n < 300) begin tick(); n++; end
    if (q1.size() != 0 || q64.size() != 0) chk(name, 0, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, prev;
    logic [255:0] blk, held;
    for (int i = 0; i < 64; i++) rk_tab[i] = {$urandom, $urandom, $urandom, $urandom};

    tick(); tick();
    chk("rst_in_ready", 256'(in_ready64), 1);
    chk("rst_out_valid", 256'(out_valid64), 0);
    chk("rst_dout", dout64, 0);
    chk("rst_rk_idx", 256'(rk_idx64), 0);
    chk("rst_dout1", dout1, 0);
    rst_n = 1'b1;
    tick();

    // One round, zero key, and key injection into the unrotated column.
    out_ready1 = 1'b1;
    send1({32'h00000001, 96'h0, 128'h0}, 128'h0,
          {32'h00002000, 96'h0, 32'h00000001, 96'h0});
    drain("single_round_timeout");
    send1(256'h0, {96'h0, 32'h80000000}, {96'h0, 32'h80000000, 128'h0});
    drain("key_inject_timeout");

    // Full 64-round run with rk_idx stepping check.
    out_ready64 = 1'b1;
    blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send64(blk, acc);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("rk_idx_%0d", k), 256'(rk_idx64), 256'(k));
      tick();
    end
    drain("full_run_timeout");

    // Backpressure: DONE held for 10 cycles while in_valid is pulsed.
    out_ready64 = 1'b0;
    blk = {8{32'hA5C3_0F1E}};
    held = model64(blk);
    send64(blk, acc);
    begin
      int n = 0;
      while (!out_valid64 && n < 200) begin tick(); n++; end
      if (!out_valid64) chk("bp_valid_timeout", 0, 1);
    end
    for (int k = 0; k < 10; k++) begin
      in_valid64 = (k >= 3 && k < 6);
      din64 = {8{32'hDEAD_BEEF}};
      chk("bp_dout_stable", dout64, held);
      chk("bp_in_ready", 256'(in_ready64), 0);
      tick();
    end
    in_valid64 = 1'b0;
    out_ready64 = 1'b1;
    drain("bp_drain_timeout");
    chk("bp_no_capture_ready", 256'(in_ready64), 1);
    chk("bp_no_capture_valid", 256'(out_valid64), 0);

    // Reset at round 20 aborts asynchronously; fresh block afterwards.
    send64({8{32'h1234_5678}}, acc);
    while (cyc < acc + 20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 256'(in_ready64), 1);
    chk("mid_rst_out_valid", 256'(out_valid64), 0);
    chk("mid_rst_dout", dout64, 0);
    chk("mid_rst_rk_idx", 256'(rk_idx64), 0);
    q64.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send64({8{32'h0BAD_F00D}}, acc);
    drain("post_rst_timeout");

    // Back-to-back blocks with in_valid and out_ready held high.
    prev = 0;
    for (int b = 0; b < 3; b++) begin
      send64({8{32'(b * 32'h1111_1111 + 32'h0102_0304)}}, acc);
      if (b > 0) chk("b2b_spacing", 256'(acc - prev), 256'd66);
      prev = acc;
    end
    drain("b2b_timeout");

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
